// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter
//   Shares one 32-bit bitwise logic unit (AND/OR/XOR/NOR) between NUM_REQ
//   requesters. Round-robin arbitration uses valid/ready handshakes, and a
//   single-entry registered result buffer supports backpressure.
//
// Ports
//   clock        in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   req_valid    in   [NUM_REQ]     per-requester request valid
//   req_op       in   [2*NUM_REQ]   op i at [2i+1:2i]: 00 AND, 01 OR, 10 XOR, 11 NOR
//   req_a        in   [32*NUM_REQ]  operand A i at [32i+31:32i]
//   req_b        in   [32*NUM_REQ]  operand B, same packing as req_a
//   req_ready    out  [NUM_REQ]     one-hot grant, combinational, 0 during reset
//   rsp_valid    out  result buffer holds a valid result
//   rsp_id       out  [ID_W]        owner of the buffered result
//   rsp_data     out  [32]          buffered result word
//   rsp_ready    in   consumer takes the result when high with rsp_valid
//   grant_count  out  [16*NUM_REQ]  saturating per-requester grant counters
//
// Build option
//   LOGIC_ARB_STATS_EN  builds the grant counters; when it is undefined,
//                       grant_count is tied to zero. Arbitration is the same
//                       in both builds.

module logic_unit_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [2*NUM_REQ-1:0]    req_op,
  input  logic [32*NUM_REQ-1:0]   req_a,
  input  logic [32*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             rsp_data,
  input  logic                    rsp_ready,
  output logic [16*NUM_REQ-1:0]   grant_count
);

  // One extra bit, so that ptr + offset cannot overflow before the modulo.
  localparam logic [ID_W:0]   NREQ_W   = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_REQ - 1);

  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q,    rsp_id_d;
  logic [31:0]       rsp_data_q,  rsp_data_d;
  logic [ID_W-1:0]   ptr_q,       ptr_d;

  logic              can_accept;
  logic              grant_found;
  logic              grant_en;
  logic [NUM_REQ-1:0] grant_oh;
  logic [ID_W-1:0]   grant_id;

  logic [1:0]        sel_op;
  logic [31:0]       sel_a;
  logic [31:0]       sel_b;
  logic [31:0]       result;

  // The buffer can take a new result when it is empty, or when the held
  // result leaves in this same cycle. This gives back-to-back throughput.
  assign can_accept = !rsp_valid_q || rsp_ready;

  // Rotating priority search. The first valid requester at or after ptr wins.
  always_comb begin
    logic [ID_W:0] cand;
    grant_oh    = '0;
    grant_id    = '0;
    grant_found = 1'b0;
    cand        = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (cand >= NREQ_W) begin
        cand = cand - NREQ_W;
      end
      if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
        grant_found                 = 1'b1;
        grant_oh[cand[ID_W-1:0]]    = 1'b1;
        grant_id                    = cand[ID_W-1:0];
      end
    end
  end

  assign grant_en  = can_accept && grant_found && !reset;
  assign req_ready = grant_en ? grant_oh : '0;

  // Operand select is driven by the one-hot grant vector, so at most one
  // term is active.
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_oh[i]) begin
        sel_op = req_op[2*i +: 2];
        sel_a  = req_a[32*i +: 32];
        sel_b  = req_b[32*i +: 32];
      end
    end
  end

  always_comb begin
    case (sel_op)
      2'b00:   result = sel_a & sel_b;
      2'b01:   result = sel_a | sel_b;
      2'b10:   result = sel_a ^ sel_b;
      default: result = ~(sel_a | sel_b);
    endcase
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    ptr_d       = ptr_q;
    if (grant_en) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = grant_id;
      rsp_data_d  = result;
      ptr_d       = (grant_id == LAST_IDX) ? '0 : grant_id + ID_W'(1);
    end else if (rsp_valid_q && rsp_ready) begin
      // A drain with no new grant keeps id and data for visibility.
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      ptr_q       <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      ptr_q       <= ptr_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

`ifdef LOGIC_ARB_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];
  logic [15:0] cnt_d [NUM_REQ];

  // Each counter saturates at all-ones instead of wrapping.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (grant_en && grant_oh[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (reset) begin
        cnt_q[i] <= '0;
      end else begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    grant_count = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      grant_count[16*i +: 16] = cnt_q[i];
    end
  end
`else
  assign grant_count = '0;
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
module tb_logic_unit_arbiter;

  localparam int N = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [2*N-1:0]    req_op;
  logic [32*N-1:0]   req_a;
  logic [32*N-1:0]   req_b;
  logic [N-1:0]      req_ready;
  logic              rsp_valid;
  logic [1:0]        rsp_id;
  logic [31:0]       rsp_data;
  logic              rsp_ready;
  logic [16*N-1:0]   grant_count;

  always #5 clock = ~clock;

  logic_unit_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data),
    .rsp_ready   (rsp_ready),
    .grant_count (grant_count)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state, valid once the first reset has been applied.
  bit          m_known = 0;
  int          m_ptr;
  bit          m_full;
  int          m_id;
  logic [31:0] m_data;
  int          m_cnt [N];
  logic [N-1:0] last_ready;

  function automatic logic [31:0] lu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: compare the DUT against the model at the negative edge,
  // advance the model, then return just after the rising edge.
  task automatic tick();
    int g;
    bit can;
    logic [N-1:0] exp_ready;
    logic [63:0]  exp_gc;
    @(negedge clock);
    g = -1;
    can = !m_full || rsp_ready;
    if (!reset && m_known && can) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    exp_ready = (g >= 0) ? N'(1 << g) : '0;
    last_ready = req_ready;
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    if (m_known) begin
      check("rsp_valid", 64'(rsp_valid), 64'(m_full));
      check("rsp_id",    64'(rsp_id),    64'(m_id));
      check("rsp_data",  64'(rsp_data),  64'(m_data));
      exp_gc = '0;
`ifdef LOGIC_ARB_STATS_EN
      for (int i = 0; i < N; i++) exp_gc[16*i +: 16] = 16'(m_cnt[i]);
`endif
      check("grant_count", 64'(grant_count), exp_gc);
    end
    if (reset) begin
      m_known = 1;
      m_ptr = 0; m_full = 0; m_id = 0; m_data = '0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else if (g >= 0) begin
      m_full = 1;
      m_id   = g;
      m_data = lu(req_op[2*g +: 2], req_a[32*g +: 32], req_b[32*g +: 32]);
      m_ptr  = (g + 1) % N;
      if (m_cnt[g] < 65535) m_cnt[g]++;
    end else if (m_full && rsp_ready) begin
      m_full = 0;
    end
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [4];
  logic [N-1:0] rr_order [6];
  logic [31:0]  held_data;

  initial begin
    vecs[0] = '{op: 2'b01, a: 32'hF0F0F0F0, b: 32'h0F0F0000, exp: 32'hFFFFF0F0};
    vecs[1] = '{op: 2'b00, a: 32'hF0F0F0F0, b: 32'h0F0F0000, exp: 32'h00000000};
    vecs[2] = '{op: 2'b10, a: 32'hF0F0F0F0, b: 32'h0F0F0000, exp: 32'hFFFFF0F0};
    vecs[3] = '{op: 2'b11, a: 32'hF0F0F0F0, b: 32'h0F0F0000, exp: 32'h00000F0F};
    rr_order[0] = 4'b0001; rr_order[1] = 4'b0010; rr_order[2] = 4'b0100;
    rr_order[3] = 4'b1000; rr_order[4] = 4'b0001; rr_order[5] = 4'b0010;

    // Reset held for two cycles with every requester valid.
    reset = 1'b1; req_valid = '1; rsp_ready = 1'b1;
    req_op = '0; req_a = '0; req_b = '0;
    #1;
    for (int c = 0; c < 2; c++) begin
      tick();
      check("reset_ready", 64'(last_ready), 64'h0);
    end
    reset = 1'b0; req_valid = '0;
    check("reset_rsp_valid", 64'(rsp_valid), 64'h0);
    check("reset_rsp_data",  64'(rsp_data),  64'h0);
    check("reset_grant_count", 64'(grant_count), 64'h0);

    // Single requester, all four ops from the table.
    for (int v = 0; v < 4; v++) begin
      req_valid = 4'b0001;
      req_op[1:0] = vecs[v].op; req_a[31:0] = vecs[v].a; req_b[31:0] = vecs[v].b;
      tick();
      check("single_ready", 64'(last_ready), 64'h1);
      check("single_id",    64'(rsp_id),     64'h0);
      check("single_valid", 64'(rsp_valid),  64'h1);
      check("single_data",  64'(rsp_data),   64'(vecs[v].exp));
    end
    req_valid = '0;
    tick();

    // Round-robin across all four requesters, starting from a fresh pointer.
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_op[2*i +: 2] = 2'(i);
      req_a[32*i +: 32] = 32'h11111111 * (i + 1);
      req_b[32*i +: 32] = 32'h0F0F0F0F;
    end
    req_valid = '1; rsp_ready = 1'b1;
    for (int s = 0; s < 6; s++) begin
      tick();
      check("rr_grant", 64'(last_ready), 64'(rr_order[s]));
      check("rr_id",    64'(rsp_id),     64'(s % N));
    end
`ifdef LOGIC_ARB_STATS_EN
    check("rr_grant_count", 64'(grant_count), 64'h0001_0001_0002_0002);
`else
    check("rr_grant_count", 64'(grant_count), 64'h0);
`endif

    // Backpressure on a full buffer with req1 waiting.
    req_valid = 4'b0010; rsp_ready = 1'b0;
    req_op[3:2] = 2'b10; req_a[63:32] = 32'h12345678; req_b[63:32] = 32'h0F0F0F0F;
    held_data = rsp_data;
    for (int s = 0; s < 5; s++) begin
      tick();
      check("bp_ready", 64'(last_ready), 64'h0);
      check("bp_data",  64'(rsp_data),   64'(held_data));
      check("bp_id",    64'(rsp_id),     64'h1);
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_release_grant", 64'(last_ready), 64'h2);
    check("bp_release_data",  64'(rsp_data),   64'h1D3B5977);
    check("bp_release_valid", 64'(rsp_valid),  64'h1);

    // Pointer at 3 with only req1 valid, then req1 and req2 competing.
    req_valid = 4'b0100; tick();
    check("skip_setup", 64'(last_ready), 64'h4);
    req_valid = 4'b0010; tick();
    check("skip_wrap",  64'(last_ready), 64'h2);
    req_valid = 4'b0110; tick();
    check("skip_next",  64'(last_ready), 64'h4);

    // Reset while the buffer is full and stalled.
    req_valid = '0; rsp_ready = 1'b0; tick();
    check("stall_valid", 64'(rsp_valid), 64'h1);
    reset = 1'b1; req_valid = '1; tick();
    check("stall_reset_ready", 64'(last_ready), 64'h0);
    reset = 1'b0;
    check("stall_reset_valid", 64'(rsp_valid), 64'h0);
    req_valid = 4'b1010; tick();
    check("post_reset_grant", 64'(last_ready), 64'h2);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      reset     = ($urandom_range(0, 59) == 0);
      req_valid = N'($urandom_range(0, 15));
      req_op    = 8'($urandom);
      req_a     = {$urandom, $urandom, $urandom, $urandom};
      req_b     = {$urandom, $urandom, $urandom, $urandom};
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares one 32-bit bitwise logic unit (AND/OR/XOR/NOR) between NUM_REQ requesters, e.g. ALU issue, branch-compare helper and test hooks.
- Round-robin arbitration with valid/ready handshakes.
- Single-entry registered result buffer with backpressure.
- Sits between requesters and the shared or/and gate datapath in the execute stage.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester index; must satisfy 2^ID_W >= NUM_REQ.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_op  in  2*NUM_REQ  op for requester i at bits [2i+1:2i]: 00 AND, 01 OR, 10 XOR, 11 NOR.
- req_a  in  32*NUM_REQ  operand A for requester i at bits [32i+31:32i].
- req_b  in  32*NUM_REQ  operand B, same packing as req_a.
- req_ready  out  NUM_REQ  one-hot; high in the cycle requester i's request is accepted.
- rsp_valid  out  1  result buffer holds a valid result.
- rsp_id  out  ID_W  index of the requester that owns the result.
- rsp_data  out  32  result word.
- rsp_ready  in  1  consumer accepts the result when high with rsp_valid.
- grant_count  out  16*NUM_REQ  per-requester grant counters (see Optional Feature).

Behaviour:
- Reset (synchronous, active-high) clears the following at the next edge:
  - rsp_valid=0, rsp_id=0, rsp_data=0.
  - Round-robin pointer ptr=0, so requester 0 has highest priority.
  - All grant counters = 0.
- req_ready is combinational and is forced to 0 while reset is high.
- Acceptance (can_accept): true when the buffer is empty (rsp_valid=0), or when it is draining this cycle (rsp_valid && rsp_ready).
- Arbitration, when can_accept and any req_valid is set:
  - Grant the first requester with req_valid set, searching ptr, ptr+1, ... wrapping modulo NUM_REQ.
  - req_ready[g]=1 for the granted requester g; all other bits 0.
  - If can_accept is false, req_ready is all 0 and ptr is held.
- On grant, at the next clock edge:
  - rsp_data <= f(req_op[g], req_a[g], req_b[g]) with f a bitwise op; no carries, full 32 bits.
  - rsp_id <= g, rsp_valid <= 1.
  - ptr <= (g+1) mod NUM_REQ.
- Latency: grant in cycle N, response visible in cycle N+1.
- Throughput: one result per cycle while rsp_ready stays high.
- Drain without a new grant: rsp_valid <= 0; rsp_data and rsp_id hold their last values.
- Backpressure: while rsp_valid=1 and rsp_ready=0:
  - rsp_data and rsp_id are stable.
  - No grants are issued.
  - Requesters keep their inputs asserted (standard valid/ready; requesters must not drop req_valid before req_ready).
- Boundaries:
  - No requests: ptr unchanged, nothing written.
  - Single requester continuously valid: granted every accept cycle, so no starvation of a lone requester.
  - ptr wrap: after a grant to NUM_REQ-1, ptr=0.
  - Requester i valid while ptr=i: i wins, since ptr position has top priority.
  - Reset while rsp_valid=1 and rsp_ready=0: the result is discarded and rsp_valid=0 next cycle.
- No combinational path from rsp_data inputs; rsp_* are driven only from registers.

Optional Feature:
- Macro: LOGIC_ARB_STATS_EN.
- Defined:
  - Each requester has a 16-bit counter, incremented on each grant to that requester.
  - Counters saturate at 0xFFFF and are cleared by reset.
  - Counter i is driven on grant_count[16i+15:16i].
- Undefined:
  - No counter logic is built.
  - grant_count is tied to all zeros.
  - Arbitration behaviour is identical either way.

Test Plan:
- Reset: assert reset 2 cycles with all req_valid=1 -> req_ready=0 throughout; after release rsp_valid=0, rsp_data=0, grant_count=0.
- Single OR: req0 valid, op=01, A=0xF0F0F0F0, B=0x0F0F0000, rsp_ready=1 -> req_ready=0001 in cycle N; cycle N+1 rsp_valid=1, rsp_id=0, rsp_data=0xFFFFF0F0. Repeat with op=00 -> 0x00000000, op=10 -> 0xFFFFF0F0, op=11 -> 0x00000F0F.
- Round-robin: all four requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,1 on consecutive cycles, rsp_id following one cycle later; with macro defined grant_count = 2,2,1,1 after 6 grants.
- Backpressure: buffer full, rsp_ready=0 for 5 cycles with req1 valid -> rsp_data and rsp_id stable, req_ready=0; raising rsp_ready -> req1 granted in that same cycle and its result appears next cycle (no bubble).
- Skip/wrap: ptr=3, only req1 valid -> req1 granted, ptr becomes 2; then req1 and req2 valid -> req2 granted first.
- Reset mid-stall: rsp_valid=1, rsp_ready=0, pulse reset -> rsp_valid=0 next cycle, ptr=0, next grant goes to the lowest valid index.
